// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: single-outstanding imem read, valid/ready hand-off to decode, PC hold/finish.
// Define FETCH_PERF_CNT_EN to add the perf_fetched / perf_stall counters.
module instr_fetch_unit #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              flush,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              pc_hold,
    output logic              finish_flag,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall,
`endif
    output logic              misalign_err
);

    localparam logic [DATA_W-1:0] ECALL_INSTR  = 32'h00000073;
    localparam logic [DATA_W-1:0] EBREAK_INSTR = 32'h00100073;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_DONE = 3'd4
    } state_t;

    function automatic logic is_finish_instr(input logic [DATA_W-1:0] instr);
        return (instr == ECALL_INSTR) || (instr == EBREAK_INSTR);
    endfunction

    function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    logic              squash_r;
    logic              squash_nxt_s;
    logic              req_nxt_s;
    logic [ADDR_W-1:0] addr_nxt_s;
    logic              valid_nxt_s;
    logic [DATA_W-1:0] out_nxt_s;
    logic [ADDR_W-1:0] ipc_nxt_s;
    logic              finish_nxt_s;
    logic              misalign_nxt_s;
    logic              accept_s;

    // A handshake cancelled by a same-cycle flush does not count as accepted.
    assign accept_s = instr_valid && instr_ready && !flush;
    assign pc_hold  = (fetch_en && !accept_s) || finish_flag;

    // Next-state and next-register logic for the fetch FSM.
    always_comb begin
        state_nxt_s    = state_r;
        squash_nxt_s   = squash_r;
        req_nxt_s      = imem_req;
        addr_nxt_s     = imem_addr;
        valid_nxt_s    = instr_valid;
        out_nxt_s      = instr_out;
        ipc_nxt_s      = instr_pc;
        finish_nxt_s   = finish_flag;
        misalign_nxt_s = misalign_err;
        case (state_r)
            S_IDLE: begin
                if (fetch_en && !finish_flag) begin
                    if (is_misaligned(pc_in)) begin
                        misalign_nxt_s = 1'b1;
                        finish_nxt_s   = 1'b1;
                        state_nxt_s    = S_DONE;
                    end else begin
                        addr_nxt_s  = pc_in;
                        req_nxt_s   = 1'b1;
                        state_nxt_s = S_REQ;
                    end
                end else begin
                    req_nxt_s = 1'b0;
                end
            end
            S_REQ: begin
                if (imem_gnt) begin
                    // A flush coinciding with the grant makes the granted read stale.
                    req_nxt_s    = 1'b0;
                    squash_nxt_s = flush;
                    state_nxt_s  = S_WAIT;
                end else if (flush) begin
                    if (is_misaligned(pc_in)) begin
                        req_nxt_s      = 1'b0;
                        misalign_nxt_s = 1'b1;
                        finish_nxt_s   = 1'b1;
                        state_nxt_s    = S_DONE;
                    end else begin
                        addr_nxt_s = pc_in;
                    end
                end else begin
                    req_nxt_s = 1'b1;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    squash_nxt_s = 1'b0;
                    if (squash_r || flush) begin
                        state_nxt_s = S_IDLE;
                    end else begin
                        out_nxt_s   = imem_rdata;
                        ipc_nxt_s   = imem_addr;
                        valid_nxt_s = 1'b1;
                        state_nxt_s = S_HOLD;
                    end
                end else if (flush) begin
                    squash_nxt_s = 1'b1;
                end else begin
                    squash_nxt_s = squash_r;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    valid_nxt_s = 1'b0;
                    out_nxt_s   = NOP_INSTR;
                    state_nxt_s = S_IDLE;
                end else if (instr_ready) begin
                    valid_nxt_s = 1'b0;
                    out_nxt_s   = NOP_INSTR;
                    if (is_finish_instr(instr_out)) begin
                        finish_nxt_s = 1'b1;
                        state_nxt_s  = S_DONE;
                    end else begin
                        state_nxt_s = S_IDLE;
                    end
                end else begin
                    valid_nxt_s = 1'b1;
                end
            end
            S_DONE: begin
                req_nxt_s   = 1'b0;
                valid_nxt_s = 1'b0;
                out_nxt_s   = NOP_INSTR;
                state_nxt_s = S_DONE;
            end
            default: begin
                req_nxt_s    = 1'b0;
                valid_nxt_s  = 1'b0;
                out_nxt_s    = NOP_INSTR;
                squash_nxt_s = 1'b0;
                state_nxt_s  = S_IDLE;
            end
        endcase
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= S_IDLE;
            squash_r     <= 1'b0;
            imem_req     <= 1'b0;
            imem_addr    <= {ADDR_W{1'b0}};
            instr_valid  <= 1'b0;
            instr_out    <= NOP_INSTR;
            instr_pc     <= {ADDR_W{1'b0}};
            finish_flag  <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            squash_r     <= squash_nxt_s;
            imem_req     <= req_nxt_s;
            imem_addr    <= addr_nxt_s;
            instr_valid  <= valid_nxt_s;
            instr_out    <= out_nxt_s;
            instr_pc     <= ipc_nxt_s;
            finish_flag  <= finish_nxt_s;
            misalign_err <= misalign_nxt_s;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Accepted-instruction and stall-cycle counters; both wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= 32'd0;
            perf_stall   <= 32'd0;
        end else begin
            if (accept_s) begin
                perf_fetched <= perf_fetched + 32'd1;
            end else begin
                perf_fetched <= perf_fetched;
            end
            if (fetch_en && pc_hold && !finish_flag) begin
                perf_stall <= perf_stall + 32'd1;
            end else begin
                perf_stall <= perf_stall;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed stimulus, behavioural imem responder, decoupled accept monitor.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic [31:0] pc_in;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic        pc_hold;
    logic        finish_flag;
    logic        misalign_err;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    instr_fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .fetch_en     (fetch_en),
        .pc_in        (pc_in),
        .flush        (flush),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_out    (instr_out),
        .instr_pc     (instr_pc),
        .pc_hold      (pc_hold),
        .finish_flag  (finish_flag),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall),
`endif
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] pc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] data, input logic [31:0] pc);
        exp_t e;
        e.data = data;
        e.pc   = pc;
        exp_q.push_back(e);
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        case (a)
            32'h00: return 32'h00500093;
            32'h04: return 32'h00A00113;
            32'h08: return 32'h00300193;
            32'h40: return 32'h00400213;
            32'h44: return 32'h00500293;
            32'h80: return 32'h00100073;
            default: return 32'hFFFFFFFF;
        endcase
    endfunction

    // Memory responder: grant after gnt_delay request cycles, data rsp_delay cycles after the grant cycle.
    int          gnt_delay = 0;
    int          rsp_delay = 0;
    int          wait_cnt = 0;
    int          rsp_cnt = 0;
    bit          rsp_pending = 1'b0;
    logic [31:0] rsp_addr = 32'h0;
    logic [31:0] last_gnt_addr = 32'h0;
    int          gnt_count = 0;
    int          req_cycles = 0;

    always @(negedge clk) begin
        imem_rvalid = 1'b0;
        imem_gnt    = 1'b0;
        if (rsp_pending) begin
            if (rsp_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_read(rsp_addr);
                rsp_pending = 1'b0;
            end else begin
                rsp_cnt--;
            end
        end
        if (imem_req && !reset) begin
            req_cycles++;
            if (wait_cnt >= gnt_delay) begin
                imem_gnt      = 1'b1;
                wait_cnt      = 0;
                rsp_pending   = 1'b1;
                rsp_cnt       = rsp_delay;
                rsp_addr      = imem_addr;
                last_gnt_addr = imem_addr;
                gnt_count++;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // Monitor: every accepted instruction must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (instr_valid && instr_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_accept: got instr %h at pc %h, expected none", instr_out, instr_pc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("accept_instr", instr_out, mon_e.data);
                    chk("accept_pc", instr_pc, mon_e.pc);
                end
            end
            if (!instr_valid) begin
                chk("nop_when_invalid", instr_out, NOP);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (instr_valid && instr_ready && !flush) begin
                seen = 1'b1;
                break;
            end
            step(1);
        end
        if (seen) begin
            step(1);
        end
        chk(name, {31'd0, seen}, 32'd1);
    endtask

    int g0;
    int r0;

    initial begin
        reset = 1'b1; fetch_en = 1'b0; pc_in = 32'h0; flush = 1'b0; instr_ready = 1'b0;
        step(2);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_out", instr_out, NOP);
        chk("rst_pc", instr_pc, 32'h0);
        chk("rst_finish", {31'd0, finish_flag}, 32'd0);
        chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
        reset = 1'b0;
        step(1);

        // Zero-wait fetch: valid on the third edge after pc_in is sampled.
        pc_in = 32'h0; fetch_en = 1'b1; instr_ready = 1'b1;
        push_exp(32'h00500093, 32'h0);
        step(1);
        chk("t1_req", {31'd0, imem_req}, 32'd1);
        chk("t1_addr", imem_addr, 32'h0);
        chk("t1_hold_req", {31'd0, pc_hold}, 32'd1);
        step(1);
        chk("t1_valid_c2", {31'd0, instr_valid}, 32'd0);
        step(1);
        chk("t1_valid_c3", {31'd0, instr_valid}, 32'd1);
        chk("t1_hold_low", {31'd0, pc_hold}, 32'd0);
        step(1);
        chk("t1_hold_after", {31'd0, pc_hold}, 32'd1);
        fetch_en = 1'b0;

        // Backpressure: decode stalls four cycles.
        pc_in = 32'h4; instr_ready = 1'b0; fetch_en = 1'b1;
        push_exp(32'h00A00113, 32'h4);
        step(3);
        for (int k = 0; k < 4; k++) begin
            chk("bp_valid", {31'd0, instr_valid}, 32'd1);
            chk("bp_out", instr_out, 32'h00A00113);
            chk("bp_hold", {31'd0, pc_hold}, 32'd1);
            chk("bp_noreq", {31'd0, imem_req}, 32'd0);
            step(1);
        end
        instr_ready = 1'b1;
        step(1);
        fetch_en = 1'b0;
        chk("bp_released", {31'd0, instr_valid}, 32'd0);

        // Flush while waiting for read data: stale word to 0x8 is dropped.
        pc_in = 32'h8; fetch_en = 1'b1; rsp_delay = 1;
        step(1);
        chk("t3_addr_old", imem_addr, 32'h8);
        step(1);
        flush = 1'b1; pc_in = 32'h40;
        push_exp(32'h00400213, 32'h40);
        step(1);
        flush = 1'b0;
        step(1);
        chk("t3_dropped", {31'd0, instr_valid}, 32'd0);
        step(1);
        chk("t3_addr_new", imem_addr, 32'h40);
        chk("t3_req_new", {31'd0, imem_req}, 32'd1);
        wait_accept("t3_accept");
        fetch_en = 1'b0; rsp_delay = 0;

        // Flush while the request is still ungranted: address retargets, one grant.
        gnt_delay = 3; pc_in = 32'h8; fetch_en = 1'b1; g0 = gnt_count;
        step(1);
        chk("t4_addr_old", imem_addr, 32'h8);
        flush = 1'b1; pc_in = 32'h44;
        push_exp(32'h00500293, 32'h44);
        step(1);
        flush = 1'b0;
        chk("t4_addr_new", imem_addr, 32'h44);
        chk("t4_req", {31'd0, imem_req}, 32'd1);
        wait_accept("t4_accept");
        fetch_en = 1'b0; gnt_delay = 0;
        chk("t4_single_gnt", gnt_count - g0, 32'd1);
        chk("t4_gnt_addr", last_gnt_addr, 32'h44);

        // EBREAK ends the program: finish is sticky until reset.
        pc_in = 32'h80; fetch_en = 1'b1;
        push_exp(32'h00100073, 32'h80);
        wait_accept("t5_accept");
        chk("t5_finish", {31'd0, finish_flag}, 32'd1);
        chk("t5_hold", {31'd0, pc_hold}, 32'd1);
        pc_in = 32'h84; g0 = gnt_count; r0 = req_cycles;
        step(5);
        chk("t5_no_req", {31'd0, imem_req}, 32'd0);
        chk("t5_no_req_cycles", req_cycles - r0, 32'd0);
        chk("t5_no_gnt", gnt_count - g0, 32'd0);
        chk("t5_finish_sticky", {31'd0, finish_flag}, 32'd1);
        fetch_en = 1'b0;
        #1;
        chk("t5_hold_fetch_off", {31'd0, pc_hold}, 32'd1);
        reset = 1'b1;
        #1;
        chk("t5_rst_finish", {31'd0, finish_flag}, 32'd0);
        step(1);
        reset = 1'b0;

        // Misaligned PC: error and finish, never a request.
        r0 = req_cycles; pc_in = 32'h6; fetch_en = 1'b1;
        step(1);
        chk("t6_misalign", {31'd0, misalign_err}, 32'd1);
        chk("t6_finish", {31'd0, finish_flag}, 32'd1);
        chk("t6_req", {31'd0, imem_req}, 32'd0);
        step(3);
        chk("t6_no_req_cycles", req_cycles - r0, 32'd0);
        chk("t6_misalign_sticky", {31'd0, misalign_err}, 32'd1);
        fetch_en = 1'b0; reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("t6_rst_misalign", {31'd0, misalign_err}, 32'd0);

        // Reset mid-transaction: the late response must be ignored.
        pc_in = 32'h0; fetch_en = 1'b1; rsp_delay = 2;
        step(2);
        chk("t7_wait_noreq", {31'd0, imem_req}, 32'd0);
        reset = 1'b1; fetch_en = 1'b0;
        step(1);
        reset = 1'b0; rsp_delay = 0;
        for (int k = 0; k < 5; k++) begin
            chk("t7_ignored", {31'd0, instr_valid}, 32'd0);
            step(1);
        end

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage directly downstream of the program counter. It takes the current PC, issues a single-outstanding read to instruction memory over a req/gnt/rvalid handshake, and presents the fetched word with a valid/ready handshake to decode. It also generates the hold/finish indication that freezes the PC. Redirects from branches flush in-flight work.

Parameters:
ADDR_W, 32, instruction address width
DATA_W, 32, instruction word width (fixed RV32; must be 32)
NOP_INSTR, 32'h00000013, value driven on instr_out when not valid (addi x0,x0,0)

Ports:
clk  in  1  clock
reset  in  1  reset
fetch_en  in  1  enables issuing new fetches
pc_in  in  ADDR_W  current PC from the PC block
flush  in  1  branch taken this cycle; in-flight fetch is stale
imem_req  out  1  memory read request
imem_addr  out  ADDR_W  request address, valid while imem_req=1
imem_gnt  in  1  request accepted
imem_rvalid  in  1  read data valid, one cycle per granted request
imem_rdata  in  DATA_W  read data
instr_valid  out  1  instruction available to decode
instr_ready  in  1  decode accepts instruction
instr_out  out  DATA_W  fetched instruction
instr_pc  out  ADDR_W  address of instr_out
pc_hold  out  1  PC must not advance this cycle
finish_flag  out  1  sticky: program end reached, to PC finish input
misalign_err  out  1  sticky: pc_in[1:0]!=0 at fetch

Behaviour:
- reset asynchronous, active-high; clock clk. On reset: state=S_IDLE, imem_req=0, imem_addr=0, instr_valid=0, instr_out=NOP_INSTR, instr_pc=0, finish_flag=0, misalign_err=0, squash=0.
- States: S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DONE.
- S_IDLE: if fetch_en && !finish_flag: if pc_in[1:0]!=0 -> set misalign_err, finish_flag, go S_DONE; else latch pc_in into imem_addr, imem_req=1, -> S_REQ.
- S_REQ: imem_req held high, imem_addr stable until imem_gnt. gnt -> imem_req=0, -> S_WAIT. flush before gnt -> re-latch pc_in (new target) and stay in S_REQ (address may change only on flush).
- S_WAIT: on imem_rvalid: if squash or flush this cycle -> discard, clear squash, -> S_IDLE; else capture rdata into instr_out, imem_addr into instr_pc, instr_valid=1, -> S_HOLD. flush without rvalid -> squash=1.
- S_HOLD: instr_valid=1, instr_out/instr_pc stable. instr_ready -> instr_valid=0, instr_out=NOP_INSTR; if instr_out is ECALL (32'h00000073) or EBREAK (32'h00100073) -> finish_flag=1, -> S_DONE; else -> S_IDLE. flush -> drop instruction (valid=0), -> S_IDLE; flush has priority over ready.
- S_DONE: absorbing until reset; no requests; instr_valid=0.
- Minimum latency: pc_in sampled to instr_valid = 3 cycles with gnt same cycle as req and rvalid cycle after gnt.
- pc_hold = fetch_en && !(instr_valid && instr_ready && !flush) || finish_flag; combinational. PC advances exactly once per accepted instruction.
- Unexpected imem_rvalid outside S_WAIT ignored.
- reset mid-transaction: outstanding memory response after reset ignored (state S_IDLE).

Optional Feature:
FETCH_PERF_CNT_EN: when defined, adds outputs perf_fetched[31:0] (increments on each instr_valid&&instr_ready handshake without flush) and perf_stall[31:0] (increments each cycle fetch_en && pc_hold && !finish_flag); both reset to 0, wrap at 2^32. When undefined, ports and counters absent; all other behaviour identical.

Test Plan:
- Zero-wait memory, pc_in=0x0, fetch_en=1, rdata=0x00500093, ready=1 -> imem_addr=0x0, instr_valid on cycle 3, instr_out=0x00500093, instr_pc=0x0, pc_hold low that cycle only.
- Backpressure: instr_ready=0 for 4 cycles -> instr_valid held, instr_out stable, pc_hold=1 throughout, no new imem_req.
- Flush in S_WAIT: req to 0x8 granted, flush with pc_in=0x40, rvalid next cycle -> data discarded, next imem_addr=0x40, no instr_valid for 0x8.
- Flush in S_REQ with gnt delayed 3 cycles -> imem_addr switches to new pc_in, single grant, fetched instr_pc = new target.
- rdata=0x00100073 accepted -> finish_flag=1 next cycle, pc_hold=1, no further imem_req until reset; reset clears finish_flag.
- pc_in=0x6 -> misalign_err=1, finish_flag=1, imem_req never asserted.
